// File: rtl/fp_round_pack.sv
// Round, renormalise and pack stage of the single-precision multiplier.
// Two registered stages (round-add, classify/pack) with a valid/ready handshake.
module fp_round_pack #(
    parameter int EXP_W  = 10,
    parameter int MANT_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [2:0]        in_grs,
    input  logic              in_zero,
    input  logic [2:0]        r_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       fp_Z,
    output logic              ovrf,
    output logic              udrf,
    output logic              inexact
);

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    logic              en1, en2;

    logic              s1_v_q, s1_v_d;
    logic              s1_sign_q, s1_sign_d;
    logic [EXP_W-1:0]  s1_exp_q, s1_exp_d;
    logic [MANT_W:0]   s1_sum_q, s1_sum_d;
    logic              s1_gnz_q, s1_gnz_d;
    logic              s1_zero_q, s1_zero_d;
    logic [2:0]        s1_mode_q, s1_mode_d;

    logic              s2_v_q, s2_v_d;
    logic [31:0]       fp_z_q, fp_z_d;
    logic              ovrf_q, ovrf_d;
    logic              udrf_q, udrf_d;
    logic              inexact_q, inexact_d;

    logic [2:0]        mode_n;
    logic              inc;

    logic              carry;
    logic [MANT_W-2:0] frac;
    logic [EXP_W:0]    exp_post;
    logic              is_ovf, is_udf;
    logic [31:0]       ovf_val;
    logic [31:0]       inf_val, max_val;

    always_comb begin
        en2      = ~s2_v_q | out_ready;
        en1      = ~s1_v_q | en2;
        in_ready = en1;
    end

    // Stage 1: rounding increment and mantissa add; unused mode codes fall back to RNE.
    always_comb begin
        mode_n = (r_mode > RM_RMM) ? RM_RNE : r_mode;
        inc    = 1'b0;
        case (mode_n)
            RM_RNE:  inc = in_grs[2] & (in_grs[1] | in_grs[0] | in_mant[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = in_sign & (|in_grs);
            RM_RUP:  inc = ~in_sign & (|in_grs);
            RM_RMM:  inc = in_grs[2];
            default: inc = 1'b0;
        endcase

        s1_v_d    = s1_v_q;
        s1_sign_d = s1_sign_q;
        s1_exp_d  = s1_exp_q;
        s1_sum_d  = s1_sum_q;
        s1_gnz_d  = s1_gnz_q;
        s1_zero_d = s1_zero_q;
        s1_mode_d = s1_mode_q;
        if (en1) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                s1_sign_d = in_sign;
                s1_exp_d  = in_exp;
                s1_sum_d  = {1'b0, in_mant} + {{MANT_W{1'b0}}, inc};
                s1_gnz_d  = |in_grs;
                s1_zero_d = in_zero;
                s1_mode_d = mode_n;
            end
        end
    end

    // Stage 2: renormalise on carry-out, then classify on the post-round exponent.
    always_comb begin
        carry    = s1_sum_q[MANT_W];
        frac     = carry ? s1_sum_q[MANT_W-1:1] : s1_sum_q[MANT_W-2:0];
        exp_post = {s1_exp_q[EXP_W-1], s1_exp_q} + {{EXP_W{1'b0}}, carry};
        is_ovf   = ~exp_post[EXP_W] && (exp_post >= (EXP_W+1)'(255));
        is_udf   = exp_post[EXP_W] || (exp_post == '0);

        inf_val  = {s1_sign_q, 8'hFF, 23'h000000};
        max_val  = {s1_sign_q, 8'hFE, 23'h7FFFFF};
        case (s1_mode_q)
            RM_RTZ:  ovf_val = max_val;
            RM_RDN:  ovf_val = s1_sign_q ? inf_val : max_val;
            RM_RUP:  ovf_val = s1_sign_q ? max_val : inf_val;
            default: ovf_val = inf_val;
        endcase

        s2_v_d    = s2_v_q;
        fp_z_d    = fp_z_q;
        ovrf_d    = ovrf_q;
        udrf_d    = udrf_q;
        inexact_d = inexact_q;
        if (en2) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                if (s1_zero_q) begin
                    fp_z_d    = {s1_sign_q, 31'h0};
                    ovrf_d    = 1'b0;
                    udrf_d    = 1'b0;
                    inexact_d = 1'b0;
                end else if (is_ovf) begin
                    fp_z_d    = ovf_val;
                    ovrf_d    = 1'b1;
                    udrf_d    = 1'b0;
                    inexact_d = 1'b1;
                end else if (is_udf) begin
                    fp_z_d    = {s1_sign_q, 31'h0};
                    ovrf_d    = 1'b0;
                    udrf_d    = 1'b1;
                    inexact_d = 1'b1;
                end else begin
                    fp_z_d    = {s1_sign_q, exp_post[7:0], frac};
                    ovrf_d    = 1'b0;
                    udrf_d    = 1'b0;
                    inexact_d = s1_gnz_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_exp_q  <= '0;
            s1_sum_q  <= '0;
            s1_gnz_q  <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_mode_q <= RM_RNE;
            s2_v_q    <= 1'b0;
            fp_z_q    <= '0;
            ovrf_q    <= 1'b0;
            udrf_q    <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_sign_q <= s1_sign_d;
            s1_exp_q  <= s1_exp_d;
            s1_sum_q  <= s1_sum_d;
            s1_gnz_q  <= s1_gnz_d;
            s1_zero_q <= s1_zero_d;
            s1_mode_q <= s1_mode_d;
            s2_v_q    <= s2_v_d;
            fp_z_q    <= fp_z_d;
            ovrf_q    <= ovrf_d;
            udrf_q    <= udrf_d;
            inexact_q <= inexact_d;
        end
    end

    assign out_valid = s2_v_q;
    assign fp_Z      = fp_z_q;
    assign ovrf      = ovrf_q;
    assign udrf      = udrf_q;
    assign inexact   = inexact_q;

endmodule

// File: tb/tb_fp_round_pack.sv
// Scoreboard bench for fp_round_pack: stimulus queue drives the input side,
// expected {fp_Z,ovrf,udrf,inexact} are queued on input handshake and popped on output handshake.
`timescale 1ns/1ps
module tb_fp_round_pack;

    typedef struct packed {
        logic        sign;
        logic [9:0]  exp;
        logic [23:0] mant;
        logic [2:0]  grs;
        logic        zero;
        logic [2:0]  mode;
        logic        has_want;
        logic [34:0] want;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_sign, in_zero;
    logic [9:0]  in_exp;
    logic [23:0] in_mant;
    logic [2:0]  in_grs, r_mode;
    logic        out_valid, out_ready;
    logic [31:0] fp_Z;
    logic        ovrf, udrf, inexact;

    stim_t       stim_q[$];
    logic [34:0] exp_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    int          n_acc = 0;

    fp_round_pack #(.EXP_W(10), .MANT_W(24)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .in_grs(in_grs), .in_zero(in_zero), .r_mode(r_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .fp_Z(fp_Z), .ovrf(ovrf), .udrf(udrf), .inexact(inexact)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: integer rounding, carry renormalisation, saturation.
    function automatic logic [34:0] model(input stim_t s);
        logic [2:0]  md;
        logic        g, r, st, any, inc;
        int          m, e;
        logic [31:0] z;
        md  = (s.mode > 3'd4) ? 3'd0 : s.mode;
        g   = s.grs[2];
        r   = s.grs[1];
        st  = s.grs[0];
        any = g | r | st;
        case (md)
            3'd0:    inc = g && (r || st || s.mant[0]);
            3'd2:    inc = s.sign && any;
            3'd3:    inc = !s.sign && any;
            3'd4:    inc = g;
            default: inc = 1'b0;
        endcase
        m = int'(s.mant) + (inc ? 1 : 0);
        e = int'($signed(s.exp));
        if (m >= 32'h0100_0000) begin
            m = m / 2;
            e = e + 1;
        end
        if (s.zero)
            return {s.sign, 31'h0, 3'b000};
        if (e >= 255) begin
            z = {s.sign, 31'h7F80_0000};
            if (md == 3'd1 || (md == 3'd2 && !s.sign) || (md == 3'd3 && s.sign))
                z = {s.sign, 31'h7F7F_FFFF};
            return {z, 3'b101};
        end
        if (e <= 0)
            return {s.sign, 31'h0, 3'b011};
        z = {s.sign, e[7:0], m[22:0]};
        return {z, 2'b00, any};
    endfunction

    function automatic stim_t mk(input logic sg, input logic [9:0] ex, input logic [23:0] mt,
                                 input logic [2:0] gr, input logic zr, input logic [2:0] md,
                                 input logic [31:0] wz, input logic [2:0] wf);
        stim_t s;
        s = '{sign: sg, exp: ex, mant: mt, grs: gr, zero: zr, mode: md,
              has_want: 1'b1, want: {wz, wf}};
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.sign = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
            0:       s.exp = 10'($urandom_range(250, 260));
            1:       s.exp = 10'(int'($urandom_range(0, 6)) - 3);
            2:       s.exp = 10'($urandom_range(1, 254));
            default: s.exp = 10'($urandom_range(0, 1023));
        endcase
        s.mant     = ($urandom_range(0, 3) == 0) ? 24'hFF_FFFF : {1'b1, 23'($urandom)};
        s.grs      = 3'($urandom_range(0, 7));
        s.zero     = ($urandom_range(0, 9) == 0);
        s.mode     = 3'($urandom_range(0, 7));
        s.has_want = 1'b0;
        s.want     = '0;
        return s;
    endfunction

    // One clock of traffic: drive head of stim_q, account for both handshakes before the edge.
    task automatic cycle(input logic rdy, output logic got, output logic [34:0] want,
                         output logic [34:0] seen);
        stim_t s;
        @(negedge clk);
        got  = 1'b0;
        want = '0;
        seen = '0;
        out_ready = rdy;
        if (stim_q.size() > 0) begin
            s        = stim_q[0];
            in_valid = 1'b1;
            in_sign  = s.sign;
            in_exp   = s.exp;
            in_mant  = s.mant;
            in_grs   = s.grs;
            in_zero  = s.zero;
            r_mode   = s.mode;
        end else begin
            in_valid = 1'b0;
        end
        #1;
        if (in_valid && in_ready) begin
            exp_q.push_back(s.has_want ? s.want : model(s));
            void'(stim_q.pop_front());
            n_acc++;
        end
        if (out_valid && out_ready) begin
            got  = 1'b1;
            seen = {fp_Z, ovrf, udrf, inexact};
            if (exp_q.size() > 0) want = exp_q.pop_front();
            else want = 'x;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_sign = 1'b0; in_exp = '0; in_mant = '0; in_grs = '0; in_zero = 1'b0; r_mode = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, fp_Z, ovrf, udrf, inexact} !== 36'h0) begin
            n_mis++;
            $display("FAIL reset_outputs: got valid/fp_Z/flags %b/%h/%b%b%b want 0/00000000/000",
                     out_valid, fp_Z, ovrf, udrf, inexact);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic got; logic [34:0] want, seen; int c;
        stim_q.push_back(mk(1, 10'd130, 24'hC60000, 3'b000, 0, 3'd0, 32'hC146_0000, 3'b000));
        stim_q.push_back(mk(0, 10'd127, 24'h800001, 3'b100, 0, 3'd0, 32'h3F80_0002, 3'b001));
        stim_q.push_back(mk(0, 10'd127, 24'h800000, 3'b100, 0, 3'd0, 32'h3F80_0000, 3'b001));
        stim_q.push_back(mk(0, 10'd127, 24'hFFFFFF, 3'b100, 0, 3'd0, 32'h4000_0000, 3'b001));
        stim_q.push_back(mk(0, 10'd254, 24'hFFFFFF, 3'b100, 0, 3'd0, 32'h7F80_0000, 3'b101));
        stim_q.push_back(mk(0, 10'd254, 24'hFFFFFF, 3'b100, 0, 3'd1, 32'h7F7F_FFFF, 3'b001));
        stim_q.push_back(mk(1, 10'd254, 24'hFFFFFF, 3'b100, 0, 3'd3, 32'hFF7F_FFFF, 3'b001));
        stim_q.push_back(mk(1, 10'd0,   24'h800000, 3'b000, 0, 3'd0, 32'h8000_0000, 3'b011));
        stim_q.push_back(mk(0, 10'd300, 24'h800000, 3'b000, 1, 3'd0, 32'h0000_0000, 3'b000));
        stim_q.push_back(mk(0, 10'd127, 24'h800001, 3'b100, 0, 3'd6, 32'h3F80_0002, 3'b001));
        stim_q.push_back(mk(0, 10'd127, 24'h800000, 3'b100, 0, 3'd4, 32'h3F80_0001, 3'b001));
        stim_q.push_back(mk(0, 10'd255, 24'h800000, 3'b000, 0, 3'd2, 32'h7F7F_FFFF, 3'b101));
        stim_q.push_back(mk(1, 10'd255, 24'h800000, 3'b000, 0, 3'd2, 32'hFF80_0000, 3'b101));
        stim_q.push_back(mk(0, 10'h3FB, 24'h800000, 3'b000, 0, 3'd0, 32'h0000_0000, 3'b011));
        stim_q.push_back(mk(1, 10'd1,   24'h800000, 3'b011, 0, 3'd2, 32'h8080_0001, 3'b001));
        c = 0;
        while (c < 60 && (stim_q.size() > 0 || exp_q.size() > 0)) begin
            cycle(1'b1, got, want, seen);
            if (got) begin
                n_cmp++;
                if (seen !== want) begin
                    n_mis++;
                    $display("FAIL directed: got {fp_Z,ovrf,udrf,inexact}=%h want %h", seen, want);
                end
            end
            c++;
        end
        if (stim_q.size() > 0 || exp_q.size() > 0) begin
            n_cmp++; n_mis++;
            $display("FAIL directed_timeout: got %0d outstanding want 0", exp_q.size() + stim_q.size());
            stim_q.delete(); exp_q.delete();
        end
    endtask

    task automatic test_random_modes();
        logic got; logic [34:0] want, seen; int c;
        for (int i = 0; i < 80; i++) stim_q.push_back(rnd());
        c = 0;
        while (c < 600 && (stim_q.size() > 0 || exp_q.size() > 0)) begin
            cycle(($urandom_range(0, 9) < 7), got, want, seen);
            if (got) begin
                n_cmp++;
                if (seen !== want) begin
                    n_mis++;
                    $display("FAIL random: got {fp_Z,ovrf,udrf,inexact}=%h want %h", seen, want);
                end
            end
            c++;
        end
        if (stim_q.size() > 0 || exp_q.size() > 0) begin
            n_cmp++; n_mis++;
            $display("FAIL random_timeout: got %0d outstanding want 0", exp_q.size() + stim_q.size());
            stim_q.delete(); exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic got; logic [34:0] want, seen; int c; int stalls;
        for (int i = 0; i < 16; i++) stim_q.push_back(rnd());
        c = 0; stalls = 0;
        while (c < 60 && (stim_q.size() > 0 || exp_q.size() > 0)) begin
            cycle(1'b1, got, want, seen);
            if (!in_ready) stalls++;
            if (got) begin
                n_cmp++;
                if (seen !== want) begin
                    n_mis++;
                    $display("FAIL back_to_back: got {fp_Z,ovrf,udrf,inexact}=%h want %h", seen, want);
                end
            end
            c++;
        end
        n_cmp++;
        if (c != 18 || stalls != 0) begin
            n_mis++;
            $display("FAIL back_to_back_rate: got %0d cycles %0d stalls want 18 cycles 0 stalls", c, stalls);
        end
    endtask

    task automatic test_backpressure();
        logic got; logic [34:0] want, seen; logic [31:0] hold; int c, acc0;
        for (int i = 0; i < 3; i++) stim_q.push_back(rnd());
        acc0 = n_acc;
        repeat (3) cycle(1'b0, got, want, seen);
        n_cmp++;
        if (in_ready !== 1'b0 || (n_acc - acc0) != 2) begin
            n_mis++;
            $display("FAIL bp_full: got in_ready=%b accepted=%0d want in_ready=0 accepted=2",
                     in_ready, n_acc - acc0);
        end
        hold = fp_Z;
        cycle(1'b0, got, want, seen);
        n_cmp++;
        if (out_valid !== 1'b1 || fp_Z !== hold) begin
            n_mis++;
            $display("FAIL bp_hold: got valid=%b fp_Z=%h want valid=1 fp_Z=%h", out_valid, fp_Z, hold);
        end
        c = 0;
        while (c < 30 && (stim_q.size() > 0 || exp_q.size() > 0)) begin
            cycle(1'b1, got, want, seen);
            if (got) begin
                n_cmp++;
                if (seen !== want) begin
                    n_mis++;
                    $display("FAIL bp_drain: got {fp_Z,ovrf,udrf,inexact}=%h want %h", seen, want);
                end
            end
            c++;
        end
        if (stim_q.size() > 0 || exp_q.size() > 0) begin
            n_cmp++; n_mis++;
            $display("FAIL bp_timeout: got %0d outstanding want 0", exp_q.size() + stim_q.size());
            stim_q.delete(); exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        logic got; logic [34:0] want, seen; int c;
        stim_q.push_back(mk(0, 10'd130, 24'hC60000, 3'b000, 0, 3'd0, 32'h4146_0000, 3'b000));
        stim_q.push_back(mk(1, 10'd127, 24'h800000, 3'b000, 0, 3'd0, 32'hBF80_0000, 3'b000));
        stim_q.push_back(mk(0, 10'd128, 24'h800000, 3'b000, 0, 3'd0, 32'h4000_0000, 3'b000));
        repeat (3) cycle(1'b0, got, want, seen);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || fp_Z !== 32'h0) begin
            n_mis++;
            $display("FAIL reset_mid: got valid=%b fp_Z=%h want valid=0 fp_Z=00000000", out_valid, fp_Z);
        end
        stim_q.delete(); exp_q.delete();
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stim_q.push_back(mk(1, 10'd129, 24'hA00000, 3'b000, 0, 3'd1, 32'hC0A0_0000, 3'b000));
        c = 0;
        while (c < 20 && (stim_q.size() > 0 || exp_q.size() > 0)) begin
            cycle(1'b1, got, want, seen);
            if (got) begin
                n_cmp++;
                if (seen !== want) begin
                    n_mis++;
                    $display("FAIL reset_recover: got {fp_Z,ovrf,udrf,inexact}=%h want %h", seen, want);
                end
            end
            c++;
        end
        if (stim_q.size() > 0 || exp_q.size() > 0) begin
            n_cmp++; n_mis++;
            $display("FAIL reset_recover_timeout: got %0d outstanding want 0", exp_q.size() + stim_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_modes();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
